multiport_fifo_v2: RTL and testbench

//  Synchronous FIFO with WRITE_PORTS write lanes and READ_PORTS read lanes, all usable in one cycle.

---
 rtl/multiport_fifo_v2.sv | 168 ++++++++++++++++
 tb/tb_multiport_fifo_v2.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multiport_fifo_v2.sv
// Synchronous multi-lane FIFO: WRITE_PORTS write lanes and READ_PORTS read lanes per cycle.
// Enabled lanes are compacted in ascending lane index. Each lane reports when it is refused,
// so no request is dropped silently.
// The ring depth can be any value >= 2, and pointers wrap by comparing against DEPTH.
// Optional macro MULTIPORT_FIFO_STICKY_ERR_EN adds the overflow_sticky/underflow_sticky outputs.
module multiport_fifo_v2 #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 2,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                srst,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]   din,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  output logic [WRITE_PORTS-1:0]              wr_fail,
  input  logic [READ_PORTS-1:0]               rd_en,
  output logic [READ_PORTS-1:0][WIDTH-1:0]    dout,
  output logic [READ_PORTS-1:0]               dout_valid,
  output logic [READ_PORTS-1:0]               rd_fail,
  output logic                                full,
  output logic                                empty,
  output logic [CW-1:0]                       data_count
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
  ,
  output logic                                overflow_sticky,
  output logic                                underflow_sticky
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [WRITE_PORTS-1:0] wr_acc, wr_rej;
  logic [AW-1:0]          wr_addr [WRITE_PORTS];
  logic [READ_PORTS-1:0]  rd_acc, rd_rej;
  logic [AW-1:0]          rd_addr [READ_PORTS];
  int unsigned            w_acc, r_acc;

  logic [WRITE_PORTS-1:0]             wr_fail_q;
  logic [READ_PORTS-1:0]              rd_fail_q, dout_valid_q;
  logic [READ_PORTS-1:0][WIDTH-1:0]   dout_q;

  // Write lane compaction: the first (DEPTH - C) enabled lanes get consecutive ring slots.
  always_comb begin : wr_alloc
    int unsigned space, k, a;
    wr_acc = '0;
    wr_rej = '0;
    space  = DEPTH - 32'(count_q);
    k      = 0;
    a      = 0;
    for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
      wr_addr[i] = '0;
      if (wr_en[i]) begin
        if (k < space) begin
          a = 32'(wr_ptr_q) + k;
          if (a >= DEPTH) a = a - DEPTH;
          wr_addr[i] = AW'(a);
          wr_acc[i]  = 1'b1;
          k          = k + 1;
        end else begin
          wr_rej[i] = 1'b1;
        end
      end
    end
    a = 32'(wr_ptr_q) + k;
    if (a >= DEPTH) a = a - DEPTH;
    wr_ptr_d = AW'(a);
    w_acc    = k;
  end

  // Read lane compaction: the first C enabled lanes are granted. Same-cycle writes are not visible.
  always_comb begin : rd_alloc
    int unsigned avail, k, a;
    rd_acc = '0;
    rd_rej = '0;
    avail  = 32'(count_q);
    k      = 0;
    a      = 0;
    for (int unsigned j = 0; j < READ_PORTS; j++) begin
      rd_addr[j] = '0;
      if (rd_en[j]) begin
        if (k < avail) begin
          a = 32'(rd_ptr_q) + k;
          if (a >= DEPTH) a = a - DEPTH;
          rd_addr[j] = AW'(a);
          rd_acc[j]  = 1'b1;
          k          = k + 1;
        end else begin
          rd_rej[j] = 1'b1;
        end
      end
    end
    a = 32'(rd_ptr_q) + k;
    if (a >= DEPTH) a = a - DEPTH;
    rd_ptr_d = AW'(a);
    r_acc    = k;
  end

  // Occupancy next state; both acceptance counts come from the start-of-cycle count.
  always_comb begin
    count_d = CW'(32'(count_q) + w_acc - r_acc);
  end

  // Pointer, count and per-lane status registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_fail_q    <= '0;
      rd_fail_q    <= '0;
      dout_valid_q <= '0;
      dout_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_fail_q    <= wr_rej;
      rd_fail_q    <= rd_rej;
      dout_valid_q <= rd_acc;
      for (int unsigned j = 0; j < READ_PORTS; j++) begin
        // Lanes not granted keep their previous data.
        if (rd_acc[j]) dout_q[j] <= mem[rd_addr[j]];
      end
    end
  end

  // Ring storage; accepted lanes always target distinct slots.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
      if (!srst && wr_acc[i]) mem[wr_addr[i]] <= din[i];
    end
  end

`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags rise together with the first wr_fail/rd_fail pulse.
  always_ff @(posedge clk) begin
    if (srst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (|wr_rej);
      underflow_q <= underflow_q | (|rd_rej);
    end
  end

  assign overflow_sticky  = overflow_q;
  assign underflow_sticky = underflow_q;
`endif

  assign wr_fail    = wr_fail_q;
  assign rd_fail    = rd_fail_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign data_count = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_multiport_fifo_v2.sv
// Directed bench for multiport_fifo_v2 with DEPTH=5, two write lanes and two read lanes.
module tb_multiport_fifo_v2;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  srst;
  logic [1:0][WIDTH-1:0] din;
  logic [1:0]            wr_en;
  logic [1:0]            wr_fail;
  logic [1:0]            rd_en;
  logic [1:0][WIDTH-1:0] dout;
  logic [1:0]            dout_valid;
  logic [1:0]            rd_fail;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         data_count;
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
  logic                  overflow_sticky;
  logic                  underflow_sticky;
`endif

  int total = 0;
  int bad   = 0;

  multiport_fifo_v2 #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .READ_PORTS (2),
    .WRITE_PORTS(2)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .din       (din),
    .wr_en     (wr_en),
    .wr_fail   (wr_fail),
    .rd_en     (rd_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .rd_fail   (rd_fail),
    .full      (full),
    .empty     (empty),
    .data_count(data_count)
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
    ,
    .overflow_sticky (overflow_sticky),
    .underflow_sticky(underflow_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic [1:0] we, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] re);
    wr_en  = we;
    din[0] = d0;
    din[1] = d1;
    rd_en  = re;
    @(posedge clk);
    #1;
  endtask

  // Check count plus the per-lane flags in one call.
  task automatic chk_st(input string tag, input int cnt, input logic [1:0] wf,
                        input logic [1:0] rf, input logic [1:0] dv);
    chk({tag, ".count"}, 32'(data_count), 32'(cnt));
    chk({tag, ".wr_fail"}, 32'(wr_fail), 32'(wf));
    chk({tag, ".rd_fail"}, 32'(rd_fail), 32'(rf));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
  endtask

  initial begin
    srst  = 1'b1;
    wr_en = '0;
    rd_en = '0;
    din   = '0;
    #2;

    // Reset held 2 cycles with every lane requesting.
    step(2'b11, 8'h11, 8'h22, 2'b11);
    step(2'b11, 8'h33, 8'h44, 2'b11);
    chk_st("reset", 0, 2'b00, 2'b00, 2'b00);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.full", 32'(full), 32'd0);
    chk("reset.dout", 32'(dout), 32'h0000);
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
    chk("reset.sticky", {30'd0, overflow_sticky, underflow_sticky}, 32'd0);
`endif
    srst = 1'b0;

    // Parallel order: A0,A1 then B0,B1, read back two per cycle.
    step(2'b11, 8'hA0, 8'hA1, 2'b00);
    chk_st("par.w0", 2, 2'b00, 2'b00, 2'b00);
    step(2'b11, 8'hB0, 8'hB1, 2'b00);
    chk_st("par.w1", 4, 2'b00, 2'b00, 2'b00);
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk_st("par.r0", 2, 2'b00, 2'b00, 2'b11);
    chk("par.r0.dout", 32'(dout), 32'hA1A0);
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk_st("par.r1", 0, 2'b00, 2'b00, 2'b11);
    chk("par.r1.dout", 32'(dout), 32'hB1B0);
    chk("par.r1.empty", 32'(empty), 32'd1);

    // Partial accept: count 4, both lanes write, only lane 0 fits.
    step(2'b11, 8'hC0, 8'hC1, 2'b00);
    step(2'b11, 8'hC2, 8'hC3, 2'b00);
    chk("pacc.pre.count", 32'(data_count), 32'd4);
    step(2'b11, 8'hC4, 8'hEE, 2'b00);
    chk_st("pacc", 5, 2'b10, 2'b00, 2'b00);
    chk("pacc.full", 32'(full), 32'd1);

    // Drain; the final read finds one entry for two lanes.
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk_st("drain0", 3, 2'b00, 2'b00, 2'b11);
    chk("drain0.dout", 32'(dout), 32'hC1C0);
    chk("drain0.full", 32'(full), 32'd0);
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
    chk("sticky.ovf", {30'd0, overflow_sticky, underflow_sticky}, 32'b10);
`endif
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk("drain1.dout", 32'(dout), 32'hC3C2);
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk_st("prd", 0, 2'b00, 2'b10, 2'b01);
    chk("prd.dout", 32'(dout), 32'hC3C4);
    chk("prd.empty", 32'(empty), 32'd1);

    // Non-contiguous lanes: only lane 1 writes, only lane 1 reads.
    step(2'b10, 8'hEE, 8'hE1, 2'b00);
    chk_st("nc.w", 1, 2'b00, 2'b00, 2'b00);
    step(2'b00, 8'h00, 8'h00, 2'b10);
    chk_st("nc.r", 0, 2'b00, 2'b00, 2'b10);
    chk("nc.dout", 32'(dout), 32'hE1C4);

    // Full with all lanes writing and reading: reads proceed, writes all fail.
    step(2'b11, 8'hF0, 8'hF1, 2'b00);
    step(2'b11, 8'hF2, 8'hF3, 2'b00);
    step(2'b01, 8'hF4, 8'h00, 2'b00);
    chk("fullrw.pre.full", 32'(full), 32'd1);
    step(2'b11, 8'h90, 8'h91, 2'b11);
    chk_st("fullrw", 3, 2'b11, 2'b00, 2'b11);
    chk("fullrw.dout", 32'(dout), 32'hF1F0);
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk("fullrw.d1", 32'(dout), 32'hF3F2);
    step(2'b00, 8'h00, 8'h00, 2'b01);
    chk_st("fullrw.d2", 0, 2'b00, 2'b00, 2'b01);
    chk("fullrw.d2.dout", 32'(dout), 32'hF3F4);

    // No bypass: write and read on empty; reads refused.
    step(2'b11, 8'h50, 8'h51, 2'b11);
    chk_st("nobyp", 2, 2'b00, 2'b11, 2'b00);
    chk("nobyp.dout", 32'(dout), 32'hF3F4);

    // Mid-burst reset discards contents; the next cycle behaves as empty.
    srst = 1'b1;
    step(2'b11, 8'h60, 8'h61, 2'b11);
    chk_st("mrst", 0, 2'b00, 2'b00, 2'b00);
    chk("mrst.dout", 32'(dout), 32'h0000);
`ifdef MULTIPORT_FIFO_STICKY_ERR_EN
    chk("mrst.sticky", {30'd0, overflow_sticky, underflow_sticky}, 32'd0);
`endif
    srst = 1'b0;
    step(2'b00, 8'h00, 8'h00, 2'b11);
    chk_st("post_rst", 0, 2'b00, 2'b11, 2'b00);

    // Wrap: prefill 3 entries, then 20 cycles of 2-in/2-out at steady count 3.
    step(2'b11, 8'h40, 8'h41, 2'b00);
    step(2'b01, 8'h42, 8'h00, 2'b00);
    chk("wrap.pre.count", 32'(data_count), 32'd3);
    for (int n = 0; n < 20; n++) begin
      step(2'b11, 8'(8'h43 + 2 * n), 8'(8'h44 + 2 * n), 2'b11);
      chk($sformatf("wrap%0d.d0", n), 32'(dout[0]), 32'(8'(8'h40 + 2 * n)));
      chk($sformatf("wrap%0d.d1", n), 32'(dout[1]), 32'(8'(8'h41 + 2 * n)));
      chk($sformatf("wrap%0d.cnt", n), 32'(data_count), 32'd3);
      chk($sformatf("wrap%0d.flags", n), {26'd0, wr_fail, rd_fail, dout_valid}, 32'b000011);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
